// File: rtl/puzzle_pkg.sv
// Shared definitions for the sliding-puzzle datapath: motion encodings,
// sequencer state type and the blank-tile move rule.
package puzzle_pkg;

    localparam logic [1:0] MOTION_UP    = 2'd0;
    localparam logic [1:0] MOTION_RIGHT = 2'd1;
    localparam logic [1:0] MOTION_DOWN  = 2'd2;
    localparam logic [1:0] MOTION_LEFT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic       legal;
        logic [3:0] next_pos;
    } blank_move_t;

    // Legality of a move on the 4x4 board and the blank position it leads to.
    // An illegal move reports the unchanged position.
    function automatic blank_move_t blank_move(input logic [3:0] pos, input logic [1:0] motion);
        blank_move_t r;
        r.legal    = 1'b0;
        r.next_pos = pos;
        case (motion)
            MOTION_UP: begin
                if (pos < 4'd12) begin
                    r.legal    = 1'b1;
                    r.next_pos = pos + 4'd4;
                end
            end
            MOTION_DOWN: begin
                if (pos >= 4'd4) begin
                    r.legal    = 1'b1;
                    r.next_pos = pos - 4'd4;
                end
            end
            MOTION_LEFT: begin
                if (pos[1:0] != 2'd3) begin
                    r.legal    = 1'b1;
                    r.next_pos = pos + 4'd1;
                end
            end
            default: begin
                if (pos[1:0] != 2'd0) begin
                    r.legal    = 1'b1;
                    r.next_pos = pos - 4'd1;
                end
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/move_fifo.sv
// Move buffer: DEPTH-entry FIFO of 2-bit moves with wrapping pointers.
// The head entry is read combinationally so the sequencer can present it
// in the same cycle it pops.
module move_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [1:0]             push_data,
    input  logic                   pop,
    output logic [1:0]             head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [1:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head      = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Storage write; contents need no reset because the count gates validity.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/move_sequencer.sv
// Move sequencer: buffers moves while idle, then replays them one per cycle
// to the puzzle stage while tracking the blank tile and counting legal moves.
module move_sequencer
    import puzzle_pkg::*;
#(
    parameter int         DEPTH     = 16,
    parameter logic [3:0] ZPOS_INIT = 4'd1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_vld,
    input  logic [1:0] in_motion,
    output logic       in_rdy,
    input  logic       start,
    output logic [1:0] motion,
    output logic       motion_vld,
    output logic       illegal,
    output logic [3:0] zero_pos,
    output logic [4:0] step_cnt,
    output logic       busy,
    output logic       done
);
    localparam int AW = $clog2(DEPTH);

    seq_state_t    r_state;
    seq_state_t    w_state_next;
    logic [3:0]    r_zero_pos;
    logic [4:0]    r_step_cnt;
    logic          w_push;
    logic          w_pop;
    logic [1:0]    w_head;
    logic          w_full;
    logic          w_empty;
    logic [AW:0]   w_count;
    blank_move_t   w_move;

    assign in_rdy   = (r_state == ST_IDLE) && !w_full;
    assign w_push   = in_vld && in_rdy;
    assign w_move   = blank_move(r_zero_pos, w_head);
    assign zero_pos = r_zero_pos;
    assign step_cnt = r_step_cnt;

    move_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (in_motion),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and output decode; a same-cycle push counts toward a run.
    always_comb begin
        w_state_next = r_state;
        motion       = 2'b00;
        motion_vld   = 1'b0;
        illegal      = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = (!w_empty || w_push) ? ST_PLAY : ST_DONE;
                end
            end
            ST_PLAY: begin
                busy       = 1'b1;
                motion_vld = 1'b1;
                motion     = w_head;
                illegal    = !w_move.legal;
                w_pop      = 1'b1;
                if (w_count == (AW+1)'(1)) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Blank tracking and legal-step counting; the count restarts with each run.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_zero_pos <= ZPOS_INIT;
            r_step_cnt <= '0;
        end else if (r_state == ST_IDLE && w_state_next == ST_PLAY) begin
            r_step_cnt <= '0;
        end else if (r_state == ST_PLAY && w_move.legal) begin
            r_zero_pos <= w_move.next_pos;
            r_step_cnt <= r_step_cnt + 5'd1;
        end
    end

endmodule

// File: tb/tb_move_sequencer.sv
// Bench for move_sequencer: directed vector table, hand-written corner
// sequences and random traffic, all checked against a queue-based model.
module tb_move_sequencer;
    localparam int         DEPTH = 16;
    localparam logic [3:0] ZPOS  = 4'd1;

    logic       clk = 1'b0;
    logic       rst, in_vld, start;
    logic [1:0] in_motion;
    logic       in_rdy, motion_vld, illegal, busy, done;
    logic [1:0] motion;
    logic [3:0] zero_pos;
    logic [4:0] step_cnt;

    always #5 clk = ~clk;

    move_sequencer #(.DEPTH(DEPTH), .ZPOS_INIT(ZPOS)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_vld     (in_vld),
        .in_motion  (in_motion),
        .in_rdy     (in_rdy),
        .start      (start),
        .motion     (motion),
        .motion_vld (motion_vld),
        .illegal    (illegal),
        .zero_pos   (zero_pos),
        .step_cnt   (step_cnt),
        .busy       (busy),
        .done       (done)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: move queue, run phase (0 idle, 1 playing, 2 finishing),
    // blank position and legal-step count.
    int m_q[$];
    int m_phase;
    int m_pos;
    int m_step;

    // Sampled DUT outputs from the most recent cycle.
    logic       s_mv, s_ill, s_done, s_rdy, s_busy;
    logic [1:0] s_mot;
    logic [3:0] s_zp;
    logic [4:0] s_sc;

    typedef struct {
        logic       r, v;
        logic [1:0] m;
        logic       s;
        logic       e_mv;
        logic [1:0] e_mot;
        logic       e_ill;
        logic [3:0] e_zp;
        logic [4:0] e_sc;
        logic       e_done;
        logic       e_rdy;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Board rule from row/column arithmetic; -1 marks an illegal move.
    function automatic int next_pos(input int pos, input int mv);
        int row = pos / 4;
        int col = pos % 4;
        case (mv)
            0:       return (row < 3) ? pos + 4 : -1;
            1:       return (col > 0) ? pos - 1 : -1;
            2:       return (row > 0) ? pos - 4 : -1;
            default: return (col < 3) ? pos + 1 : -1;
        endcase
    endfunction

    function automatic vec_t mk(input logic r, v, input logic [1:0] m, input logic s,
                                input logic e_mv, input logic [1:0] e_mot, input logic e_ill,
                                input logic [3:0] e_zp, input logic [4:0] e_sc,
                                input logic e_done, e_rdy);
        vec_t x;
        x.r = r; x.v = v; x.m = m; x.s = s;
        x.e_mv = e_mv; x.e_mot = e_mot; x.e_ill = e_ill; x.e_zp = e_zp;
        x.e_sc = e_sc; x.e_done = e_done; x.e_rdy = e_rdy;
        return x;
    endfunction

    // One clock cycle: drive, sample mid-cycle, compare with model, advance model.
    task automatic cycle(input logic r, v, input logic [1:0] m, input logic s);
        int e_mv, e_mot, e_ill, e_done, e_rdy, e_busy, np;
        rst = r; in_vld = v; in_motion = m; start = s;
        #3;
        s_mv = motion_vld; s_mot = motion; s_ill = illegal; s_done = done;
        s_rdy = in_rdy; s_busy = busy; s_zp = zero_pos; s_sc = step_cnt;
        e_mv = 0; e_mot = 0; e_ill = 0; e_done = 0; e_rdy = 0; e_busy = 0;
        if (m_phase == 0) begin
            e_rdy = (m_q.size() < DEPTH) ? 1 : 0;
        end else if (m_phase == 1 && m_q.size() > 0) begin
            e_mv = 1; e_busy = 1; e_mot = m_q[0];
            e_ill = (next_pos(m_pos, m_q[0]) < 0) ? 1 : 0;
        end else if (m_phase == 2) begin
            e_done = 1;
        end
        chk("model_motion_vld", s_mv,   e_mv);
        chk("model_motion",     s_mot,  e_mot);
        chk("model_illegal",    s_ill,  e_ill);
        chk("model_done",       s_done, e_done);
        chk("model_in_rdy",     s_rdy,  e_rdy);
        chk("model_busy",       s_busy, e_busy);
        chk("model_zero_pos",   s_zp,   m_pos);
        chk("model_step_cnt",   s_sc,   m_step);
        if (r) begin
            m_q.delete(); m_phase = 0; m_pos = int'(ZPOS); m_step = 0;
        end else begin
            case (m_phase)
                0: begin
                    if (v && m_q.size() < DEPTH) m_q.push_back(int'(m));
                    if (s) begin
                        if (m_q.size() > 0) begin
                            m_phase = 1; m_step = 0;
                        end else begin
                            m_phase = 2;
                        end
                    end
                end
                1: begin
                    np = next_pos(m_pos, m_q[0]);
                    void'(m_q.pop_front());
                    if (np >= 0) begin
                        m_pos = np; m_step++;
                    end
                    if (m_q.size() == 0) m_phase = 2;
                end
                default: m_phase = 0;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst = 1'b1; in_vld = 1'b0; in_motion = 2'd0; start = 1'b0;
        m_q.delete(); m_phase = 0; m_pos = int'(ZPOS); m_step = 0;
        @(posedge clk);
        #1;

        // Directed vectors: r v m s | mv mot ill zp sc done rdy
        tbl.push_back(mk(1,0,0,0, 0,0,0,1,0,0,1));   // reset state
        tbl.push_back(mk(0,1,3,0, 0,0,0,1,0,0,1));   // push LEFT
        tbl.push_back(mk(0,1,3,0, 0,0,0,1,0,0,1));   // push LEFT
        tbl.push_back(mk(0,1,0,0, 0,0,0,1,0,0,1));   // push UP
        tbl.push_back(mk(0,0,0,1, 0,0,0,1,0,0,1));   // start
        tbl.push_back(mk(0,0,0,0, 1,3,0,1,0,0,0));
        tbl.push_back(mk(0,0,0,0, 1,3,0,2,1,0,0));
        tbl.push_back(mk(0,0,0,0, 1,0,0,3,2,0,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,7,3,1,0));   // done
        tbl.push_back(mk(1,0,0,0, 0,0,0,7,3,0,1));   // reset back to pos 1
        tbl.push_back(mk(0,1,2,0, 0,0,0,1,0,0,1));   // push DOWN
        tbl.push_back(mk(0,0,0,1, 0,0,0,1,0,0,1));   // start
        tbl.push_back(mk(0,0,0,0, 1,2,1,1,0,0,0));   // illegal DOWN
        tbl.push_back(mk(0,0,0,0, 0,0,0,1,0,1,0));
        tbl.push_back(mk(0,1,1,1, 0,0,0,1,0,0,1));   // push RIGHT with start
        tbl.push_back(mk(0,0,0,0, 1,1,0,1,0,0,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,1,1,0));
        tbl.push_back(mk(0,0,0,1, 0,0,0,0,1,0,1));   // start on empty buffer
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,1,1,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,1,0,1));

        foreach (tbl[i]) begin
            cycle(tbl[i].r, tbl[i].v, tbl[i].m, tbl[i].s);
            chk($sformatf("vec%0d_motion_vld", i), s_mv,   tbl[i].e_mv);
            chk($sformatf("vec%0d_motion", i),     s_mot,  tbl[i].e_mot);
            chk($sformatf("vec%0d_illegal", i),    s_ill,  tbl[i].e_ill);
            chk($sformatf("vec%0d_zero_pos", i),   s_zp,   tbl[i].e_zp);
            chk($sformatf("vec%0d_step_cnt", i),   s_sc,   tbl[i].e_sc);
            chk($sformatf("vec%0d_done", i),       s_done, tbl[i].e_done);
            chk($sformatf("vec%0d_in_rdy", i),     s_rdy,  tbl[i].e_rdy);
            $display("vec %0d: mv=%0d mot=%0d ill=%0d zp=%0d sc=%0d done=%0d rdy=%0d",
                     i, s_mv, s_mot, s_ill, s_zp, s_sc, s_done, s_rdy);
        end

        // Overfill: 17 back-to-back pushes, only 16 stored and replayed.
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 17; i++) begin
            cycle(0, 1, 2'($urandom_range(0, 3)), 0);
            if (i == 15) chk("full_in_rdy_16th", s_rdy, 1);
            if (i == 16) chk("full_in_rdy_17th", s_rdy, 0);
        end
        cycle(0, 0, 0, 1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(0, 0, 0, 0);
            if (s_mv) n++;
        end
        chk("full_play_count", 8'(n), 8'd16);
        $display("overfill: issued %0d moves", n);

        // Reset on the second cycle of a five-move run.
        cycle(1, 0, 0, 0);
        cycle(0, 1, 2'd3, 0);
        cycle(0, 1, 2'd0, 0);
        cycle(0, 1, 2'd0, 0);
        cycle(0, 1, 2'd1, 0);
        cycle(0, 1, 2'd2, 0);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        chk("abort_play_before_reset", s_mv, 1);
        cycle(0, 0, 0, 0);
        chk("abort_motion_vld", s_mv, 0);
        chk("abort_zero_pos", s_zp, ZPOS);
        chk("abort_no_done", s_done, 0);
        chk("abort_in_rdy", s_rdy, 1);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
        chk("abort_buffer_empty_done", s_done, 1);
        chk("abort_buffer_empty_mv", s_mv, 0);
        $display("abort: zp=%0d done=%0d", s_zp, s_done);

        // Random traffic against the model.
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
                  1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)),
                  ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
        end
        $display("random: 400 cycles, final zp=%0d sc=%0d", s_zp, s_sc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
